// File: rtl/sprite_dma_master_if.sv
// AHB-Lite signal bundle between the sprite DMA initiator and the bus matrix.
// master drives address/control/write data; slave returns ready, read data and response.
interface sprite_dma_master_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;

  modport master (
    output HADDR, HTRANS, HSIZE, HBURST, HPROT, HWRITE, HWDATA,
    input  HREADY, HRDATA, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HSIZE, HBURST, HPROT, HWRITE, HWDATA,
    output HREADY, HRDATA, HRESP
  );
endinterface

// File: rtl/sprite_dma_master.sv
// Non-pipelined AHB-Lite initiator copying 32-bit sprite attribute words from memory to spriteRam.
// Each word is one SINGLE read followed by one SINGLE write; only one transfer is ever outstanding.
module sprite_dma_master #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  start,
  input  logic [31:0]           srcAddr,
  input  logic [31:0]           dstAddr,
  input  logic [ADDR_WIDTH:0]   wordCount,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   xferCount,
  output logic [2:0]            dbg_state,
  sprite_dma_master_if.master   bus
);

  // Handshake: an address phase completes on the rising edge where HTRANS=NONSEQ and HREADY=1;
  // a data phase completes on the edge where HREADY=1, and HRESP[0]=1 in a data phase aborts.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_D  = 3'd2,
    S_WR_A  = 3'd3,
    S_WR_D  = 3'd4,
    S_ABORT = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] CNT_ZERO = '0;

  state_t              state;
  state_t              state_nxt;
  logic [31:0]         src_q;
  logic [31:0]         dst_q;
  logic [31:0]         buf_q;
  logic [ADDR_WIDTH:0] count_q;
  logic [ADDR_WIDTH:0] xfer_inc;
  logic                accept;
  logic                unused_bits;

  assign accept      = (state == S_IDLE) && start;
  assign xfer_inc    = xferCount + CNT_ONE;
  assign dbg_state   = state;
  assign unused_bits = ^{bus.HRESP[1], srcAddr[1:0], dstAddr[1:0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (wordCount == CNT_ZERO) ? S_FIN : S_RD_A;
      S_RD_A:  if (bus.HREADY) state_nxt = S_RD_D;
      S_RD_D: begin
        if (bus.HRESP[0])     state_nxt = S_ABORT;
        else if (bus.HREADY)  state_nxt = S_WR_A;
      end
      S_WR_A:  if (bus.HREADY) state_nxt = S_WR_D;
      S_WR_D: begin
        if (bus.HRESP[0])     state_nxt = S_ABORT;
        else if (bus.HREADY)  state_nxt = (xfer_inc == count_q) ? S_FIN : S_RD_A;
      end
      S_ABORT: state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      src_q     <= '0;
      dst_q     <= '0;
      buf_q     <= '0;
      count_q   <= '0;
      xferCount <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= (state == S_FIN);
      if (accept) begin
        src_q     <= {srcAddr[31:2], 2'b00};
        dst_q     <= {dstAddr[31:2], 2'b00};
        count_q   <= wordCount;
        xferCount <= '0;
        err       <= 1'b0;
        busy      <= 1'b1;
      end
      if (state == S_RD_D) begin
        if (bus.HRESP[0]) begin
          err <= 1'b1;
        end else if (bus.HREADY) begin
          buf_q <= bus.HRDATA;
          src_q <= src_q + 32'd4;
        end
      end
      if (state == S_WR_D) begin
        if (bus.HRESP[0]) begin
          err <= 1'b1;
        end else if (bus.HREADY) begin
          dst_q     <= dst_q + 32'd4;
          xferCount <= xfer_inc;
        end
      end
      if (state == S_FIN) busy <= 1'b0;
    end
  end

  // Address/control are decoded straight from state so a stalled phase holds them without extra flops.
  always_comb begin
    bus.HTRANS = 2'b00;
    bus.HADDR  = '0;
    bus.HWRITE = 1'b0;
    bus.HWDATA = '0;
    case (state)
      S_RD_A: begin
        bus.HTRANS = 2'b10;
        bus.HADDR  = src_q;
      end
      S_WR_A: begin
        bus.HTRANS = 2'b10;
        bus.HADDR  = dst_q;
        bus.HWRITE = 1'b1;
      end
      S_WR_D:  bus.HWDATA = buf_q;
      default: ;
    endcase
  end

  assign bus.HSIZE  = 3'b010;
  assign bus.HBURST = 3'b000;
  assign bus.HPROT  = 4'b0011;

endmodule

// File: tb/tb_sprite_dma_master.sv
// Bench for sprite_dma_master: behavioural AHB slave with stall/error injection and
// address/data scoreboards filled when each transfer is launched.
module tb_sprite_dma_master;
  localparam int AW = 6;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          start;
  logic [31:0]   srcAddr;
  logic [31:0]   dstAddr;
  logic [AW:0]   wordCount;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   xferCount;
  logic [2:0]    dbg_state;

  sprite_dma_master_if bus();

  sprite_dma_master #(.ADDR_WIDTH(AW)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .start     (start),
    .srcAddr   (srcAddr),
    .dstAddr   (dstAddr),
    .wordCount (wordCount),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .xferCount (xferCount),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  always #10 HCLK = ~HCLK;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_ra_q[$];
  logic [31:0] exp_wa_q[$];
  logic [31:0] exp_wd_q[$];

  bit          dp_pending = 1'b0;
  bit          dp_write = 1'b0;
  logic [31:0] dp_addr = '0;
  int          rd_a_stall = 0;
  int          wr_d_stall = 0;
  int          err_rd = 0;
  int          rd_num = 0;
  int          err_left = 0;
  int          nonseq_cnt = 0;

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Slave model: decides this cycle's response at the falling edge from the DUT's current outputs.
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      bus.HREADY = 1'b1;
      bus.HRESP  = 2'b00;
      bus.HRDATA = '0;
      dp_pending = 1'b0;
      err_left   = 0;
    end else if (dp_pending) begin
      bus.HRDATA = '0;
      if (err_left == 2) begin
        bus.HREADY = 1'b0;
        bus.HRESP  = 2'b01;
        err_left   = 1;
      end else if (err_left == 1) begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 2'b01;
        err_left   = 0;
        dp_pending = 1'b0;
      end else if (dp_write) begin
        bus.HRESP = 2'b00;
        checks++;
        if (exp_wd_q.size() == 0) begin
          failures++;
          $display("FAIL wdata_extra: got write data %h, none expected", bus.HWDATA);
        end else if (bus.HWDATA !== exp_wd_q[0]) begin
          failures++;
          $display("FAIL wdata: got %h, expected %h", bus.HWDATA, exp_wd_q[0]);
        end
        if (wr_d_stall > 0) begin
          bus.HREADY = 1'b0;
          wr_d_stall--;
        end else begin
          bus.HREADY = 1'b1;
          if (exp_wd_q.size() != 0) void'(exp_wd_q.pop_front());
          dp_pending = 1'b0;
        end
      end else begin
        bus.HRESP  = 2'b00;
        bus.HREADY = 1'b1;
        bus.HRDATA = src_word(dp_addr);
        dp_pending = 1'b0;
      end
    end else begin
      bus.HRESP  = 2'b00;
      bus.HRDATA = '0;
      bus.HREADY = 1'b1;
      if (bus.HTRANS == 2'b10) begin
        checks++;
        if (bus.HWRITE) begin
          if (exp_wa_q.size() == 0) begin
            failures++;
            $display("FAIL waddr_extra: got write to %h, none expected", bus.HADDR);
          end else if (bus.HADDR !== exp_wa_q[0]) begin
            failures++;
            $display("FAIL waddr: got %h, expected %h", bus.HADDR, exp_wa_q[0]);
          end
        end else begin
          if (exp_ra_q.size() == 0) begin
            failures++;
            $display("FAIL raddr_extra: got read of %h, none expected", bus.HADDR);
          end else if (bus.HADDR !== exp_ra_q[0]) begin
            failures++;
            $display("FAIL raddr: got %h, expected %h", bus.HADDR, exp_ra_q[0]);
          end
        end
        if (!bus.HWRITE && rd_a_stall > 0) begin
          bus.HREADY = 1'b0;
          rd_a_stall--;
        end else begin
          nonseq_cnt++;
          dp_pending = 1'b1;
          dp_write   = bus.HWRITE;
          dp_addr    = bus.HADDR;
          if (bus.HWRITE) begin
            if (exp_wa_q.size() != 0) void'(exp_wa_q.pop_front());
          end else begin
            if (exp_ra_q.size() != 0) void'(exp_ra_q.pop_front());
            rd_num++;
            if (rd_num == err_rd) err_left = 2;
          end
        end
      end
    end
  end

  task automatic push_expect(input logic [31:0] src, input logic [31:0] dst,
                             input int n_rd, input int n_wr);
    for (int i = 0; i < n_rd; i++) exp_ra_q.push_back(src + 32'(4 * i));
    for (int i = 0; i < n_wr; i++) begin
      exp_wa_q.push_back(dst + 32'(4 * i));
      exp_wd_q.push_back(src_word(src + 32'(4 * i)));
    end
  endtask

  task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst, input int cnt);
    @(negedge HCLK);
    #1;
    srcAddr   = src;
    dstAddr   = dst;
    wordCount = AW'(0) + (AW+1)'(cnt);
    rd_num    = 0;
    start     = 1'b1;
  endtask

  // Cycle 0 is the start cycle; returns the cycle in which done is seen, or -1 on timeout.
  task automatic wait_done(input int repulse_at, output int cyc, output int busy_cyc);
    int n;
    n = 0;
    busy_cyc = 0;
    cyc = -1;
    while (n < 1000) begin
      @(negedge HCLK);
      n++;
      if (n == 1) start = 1'b0;
      if (repulse_at > 0 && n == repulse_at) begin
        srcAddr   = 32'h1234_5678;
        dstAddr   = 32'h8765_4320;
        wordCount = 7'd1;
        start     = 1'b1;
      end
      if (repulse_at > 0 && n == repulse_at + 1) start = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        cyc = n;
        break;
      end
    end
    if (cyc < 0) begin
      failures++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    HRESETn   = 1'b0;
    start     = 1'b0;
    srcAddr   = '0;
    dstAddr   = '0;
    wordCount = '0;
    bus.HREADY = 1'b1;
    bus.HRESP  = 2'b00;
    bus.HRDATA = '0;
    repeat (3) @(negedge HCLK);
    checks++;
    if ({busy, done, err, xferCount, dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset_status: busy=%b done=%b err=%b xfer=%0d state=%0d, expected all 0",
               busy, done, err, xferCount, dbg_state);
    end
    checks++;
    if ({bus.HTRANS, bus.HADDR, bus.HWDATA, bus.HWRITE} !== '0) begin
      failures++;
      $display("FAIL reset_bus: htrans=%b haddr=%h hwdata=%h hwrite=%b, expected 0",
               bus.HTRANS, bus.HADDR, bus.HWDATA, bus.HWRITE);
    end
    checks++;
    if (bus.HSIZE !== 3'b010 || bus.HBURST !== 3'b000 || bus.HPROT !== 4'b0011) begin
      failures++;
      $display("FAIL bus_const: hsize=%b hburst=%b hprot=%b, expected 010/000/0011",
               bus.HSIZE, bus.HBURST, bus.HPROT);
    end
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  task automatic test_basic();
    int cyc, bc;
    push_expect(32'h2000_0000, 32'h5000_0000, 4, 4);
    start_xfer(32'h2000_0000, 32'h5000_0000, 4);
    wait_done(0, cyc, bc);
    checks++;
    if (cyc !== 18) begin failures++; $display("FAIL basic_done_cycle: got %0d, expected 18", cyc); end
    checks++;
    if (xferCount !== 7'd4) begin failures++; $display("FAIL basic_xfer: got %0d, expected 4", xferCount); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL basic_err: got %b, expected 0", err); end
    checks++;
    if (bc !== 17) begin failures++; $display("FAIL basic_busy_cycles: got %0d, expected 17", bc); end
    checks++;
    if (exp_ra_q.size() + exp_wa_q.size() + exp_wd_q.size() != 0) begin
      failures++;
      $display("FAIL basic_drain: %0d/%0d/%0d left, expected 0", exp_ra_q.size(), exp_wa_q.size(), exp_wd_q.size());
    end
  endtask

  task automatic test_zero_count();
    int cyc, bc, ns0;
    ns0 = nonseq_cnt;
    start_xfer(32'h2000_0400, 32'h5000_0400, 0);
    wait_done(0, cyc, bc);
    checks++;
    if (cyc !== 2) begin failures++; $display("FAIL zero_done_cycle: got %0d, expected 2", cyc); end
    checks++;
    if (bc !== 1) begin failures++; $display("FAIL zero_busy_cycles: got %0d, expected 1", bc); end
    checks++;
    if (nonseq_cnt !== ns0) begin failures++; $display("FAIL zero_nonseq: got %0d transfers, expected 0", nonseq_cnt - ns0); end
    checks++;
    if (xferCount !== 7'd0) begin failures++; $display("FAIL zero_xfer: got %0d, expected 0", xferCount); end
  endtask

  task automatic test_wait_states();
    int cyc, bc;
    rd_a_stall = 3;
    wr_d_stall = 3;
    push_expect(32'h2000_1000, 32'h5000_0100, 4, 4);
    start_xfer(32'h2000_1000, 32'h5000_0100, 4);
    wait_done(0, cyc, bc);
    checks++;
    if (cyc !== 24) begin failures++; $display("FAIL wait_done_cycle: got %0d, expected 24", cyc); end
    checks++;
    if (rd_a_stall != 0 || wr_d_stall != 0) begin
      failures++;
      $display("FAIL wait_stalls_used: rd=%0d wr=%0d left, expected 0", rd_a_stall, wr_d_stall);
    end
    checks++;
    if (xferCount !== 7'd4) begin failures++; $display("FAIL wait_xfer: got %0d, expected 4", xferCount); end
    checks++;
    if (exp_ra_q.size() + exp_wa_q.size() + exp_wd_q.size() != 0) begin
      failures++;
      $display("FAIL wait_drain: %0d/%0d/%0d left, expected 0", exp_ra_q.size(), exp_wa_q.size(), exp_wd_q.size());
    end
  endtask

  task automatic test_error();
    int cyc, bc;
    err_rd = 3;
    push_expect(32'h2000_2000, 32'h5000_0200, 3, 2);
    start_xfer(32'h2000_2000, 32'h5000_0200, 5);
    wait_done(0, cyc, bc);
    err_rd = 0;
    checks++;
    if (cyc !== 13) begin failures++; $display("FAIL err_done_cycle: got %0d, expected 13", cyc); end
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_flag: got %b, expected 1", err); end
    checks++;
    if (xferCount !== 7'd2) begin failures++; $display("FAIL err_xfer: got %0d, expected 2", xferCount); end
    checks++;
    if (exp_ra_q.size() + exp_wa_q.size() + exp_wd_q.size() != 0) begin
      failures++;
      $display("FAIL err_drain: %0d/%0d/%0d left, expected 0", exp_ra_q.size(), exp_wa_q.size(), exp_wd_q.size());
    end
    repeat (2) @(negedge HCLK);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b, expected 1", err); end
    push_expect(32'h2000_2400, 32'h5000_0300, 1, 1);
    start_xfer(32'h2000_2400, 32'h5000_0300, 1);
    wait_done(0, cyc, bc);
    checks++;
    if (err !== 1'b0 || cyc !== 6 || xferCount !== 7'd1) begin
      failures++;
      $display("FAIL err_clear: err=%b cycle=%0d xfer=%0d, expected 0/6/1", err, cyc, xferCount);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    push_expect(32'hFFFF_FFF8, 32'h5000_0000, 64, 64);
    checks++;
    if (exp_ra_q[2] !== 32'h0000_0000) begin
      failures++;
      $display("FAIL wrap_model: third read %h, expected 00000000", exp_ra_q[2]);
    end
    start_xfer(32'hFFFF_FFF8, 32'h5000_0000, 64);
    wait_done(10, cyc, bc);
    checks++;
    if (cyc !== 258) begin failures++; $display("FAIL b2b_done_cycle: got %0d, expected 258", cyc); end
    checks++;
    if (xferCount !== 7'd64) begin failures++; $display("FAIL b2b_xfer: got %0d, expected 64", xferCount); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL b2b_err: got %b, expected 0", err); end
    checks++;
    if (exp_ra_q.size() + exp_wa_q.size() + exp_wd_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: %0d/%0d/%0d left, expected 0", exp_ra_q.size(), exp_wa_q.size(), exp_wd_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc, bc;
    push_expect(32'h2000_3000, 32'h5000_0200, 8, 8);
    start_xfer(32'h2000_3000, 32'h5000_0200, 8);
    for (int n = 1; n <= 19; n++) begin
      @(negedge HCLK);
      if (n == 1) start = 1'b0;
    end
    checks++;
    if (bus.HTRANS !== 2'b10 || bus.HWRITE !== 1'b1 || bus.HADDR !== 32'h5000_0210 || xferCount !== 7'd4) begin
      failures++;
      $display("FAIL mid_pre_state: htrans=%b hwrite=%b haddr=%h xfer=%0d, expected 10/1/50000210/4",
               bus.HTRANS, bus.HWRITE, bus.HADDR, xferCount);
    end
    #1;
    HRESETn = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, xferCount, bus.HTRANS, bus.HADDR, bus.HWDATA, bus.HWRITE} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs: busy=%b done=%b err=%b xfer=%0d htrans=%b haddr=%h hwdata=%h, expected 0",
               busy, done, err, xferCount, bus.HTRANS, bus.HADDR, bus.HWDATA);
    end
    exp_ra_q.delete();
    exp_wa_q.delete();
    exp_wd_q.delete();
    dp_pending = 1'b0;
    err_left   = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge HCLK);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL mid_no_done: done=%b busy=%b during reset, expected 0", done, busy);
      end
    end
    HRESETn = 1'b1;
    push_expect(32'h2000_4000, 32'h5000_0000, 2, 2);
    start_xfer(32'h2000_4000, 32'h5000_0000, 2);
    wait_done(0, cyc, bc);
    checks++;
    if (cyc !== 10 || xferCount !== 7'd2 || err !== 1'b0) begin
      failures++;
      $display("FAIL mid_recover: cycle=%0d xfer=%0d err=%b, expected 10/2/0", cyc, xferCount, err);
    end
    checks++;
    if (exp_ra_q.size() + exp_wa_q.size() + exp_wd_q.size() != 0) begin
      failures++;
      $display("FAIL mid_drain: %0d/%0d/%0d left, expected 0", exp_ra_q.size(), exp_wa_q.size(), exp_wd_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_wait_states();
    test_error();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge HCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
